uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 8, meaning the number of FIFO entries (power of two, minimum 2).
REQ-002 The block SHALL provide parameter CW, default 4, meaning the width of the count output (equal to log2(DEPTH)+1).
REQ-003 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit: synchronous, active-low reset (asserted when 0, sampled on the rising edge of clk).
REQ-005 The block SHALL provide port rx_done, input, 1 bit: one-cycle strobe from the UART receiver; dout and err are valid in that cycle.
REQ-006 The block SHALL provide port dout, input, 8 bits: received data byte from the UART receiver.
REQ-007 The block SHALL provide port err, input, 3 bits: receiver status for the byte; any nonzero bit marks the frame as erroneous.
REQ-008 The block SHALL provide port rd_en, input, 1 bit: consumer read request.
REQ-009 The block SHALL provide port clr_stat, input, 1 bit: clears the ovf flag and err_cnt.
REQ-010 The block SHALL provide port rd_data, output, 8 bits: data byte popped by the last accepted read.
REQ-011 The block SHALL provide port rd_err, output, 3 bits: err value stored with rd_data.
REQ-012 The block SHALL provide port rd_valid, output, 1 bit: one-cycle pulse marking rd_data and rd_err as valid.
REQ-013 The block SHALL provide ports empty and full, output, 1 bit each: FIFO occupancy flags.
REQ-014 The block SHALL provide port count, output, CW bits: number of stored entries (0..DEPTH).
REQ-015 The block SHALL provide port ovf, output, 1 bit: sticky flag, set when a byte is dropped.
REQ-016 The block SHALL provide port err_cnt, output, 8 bits: saturating count of erroneous frames written.

Function
REQ-017 Storage: each entry holds {err, dout} (11 bits); registered write and read pointers, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-018 Write: rx_done=1 and not full -> {err, dout} stored at the write pointer; pointer +1; count +1 unless a read is accepted in the same cycle.
REQ-019 Read: rd_en=1 and not empty -> the entry at the read pointer goes to rd_data/rd_err on the next edge; rd_valid=1 for exactly that cycle; pointer +1.
REQ-020 Read latency: 1 cycle from the rd_en sample to rd_valid; rd_data/rd_err hold their last value while rd_valid=0.
REQ-021 Read when empty: ignored; pointers, count and rd_data unchanged; rd_valid=0; no error flag.
REQ-022 Simultaneous read and write, not empty and not full: both accepted; count unchanged.
REQ-023 Simultaneous read and write when empty: write accepted; read ignored (no rd_valid); count becomes 1; no bypass.
REQ-024 Simultaneous read and write when full: both accepted; the read returns the oldest entry; count stays DEPTH; ovf not set.
REQ-025 Overflow: rx_done=1, full=1 and no accepted read -> byte dropped; FIFO contents unchanged; ovf set to 1 next edge.
REQ-026 Flags are derived from registered count: empty = (count==0), full = (count==DEPTH); both update the cycle after the causing edge.
REQ-027 err_cnt: +1 for each accepted write with err!=0, saturating at 255; dropped bytes are not counted.
REQ-028 clr_stat=1: ovf and err_cnt cleared to 0 next edge. A same-cycle overflow leaves ovf=1 (set wins). A same-cycle erroneous write leaves err_cnt=1.
REQ-029 Pointers SHALL NOT be cleared by clr_stat; only reset empties the FIFO.

Reset
REQ-030 reset=0 at a rising edge SHALL set: both pointers 0, count 0, empty 1, full 0, rd_valid 0, rd_data 0, rd_err 0, ovf 0, err_cnt 0.
REQ-031 Reset SHALL override rx_done, rd_en and clr_stat in the same cycle; stored entries are discarded and memory contents need not be cleared.
REQ-032 Reset asserted mid-operation (FIFO partially full, read pending) SHALL take effect at the next edge; a pending rd_valid SHALL NOT appear.

Verification
REQ-033 Write 0xA5 with err=000, then rd_en one cycle later -> rd_valid the following cycle with rd_data=0xA5, rd_err=000; empty=1 afterwards.
REQ-034 Write 8 bytes 0x01..0x08 -> full=1, count=8; a 9th write of 0xFF -> ovf=1, count=8; 8 reads return 0x01..0x08 in order, no 0xFF.
REQ-035 When full, rx_done and rd_en in the same cycle with dout=0x55 -> read returns the oldest byte, count=8, ovf=0; 0x55 is read last.
REQ-036 Write 3 frames with err=001, 100, 000 -> err_cnt=2; clr_stat -> err_cnt=0; 300 erroneous writes with interleaved reads -> err_cnt=255.
REQ-037 Write 4 bytes, then reset=0 for one cycle together with rd_en=1 -> no rd_valid, count=0, empty=1, ovf=0; a subsequent write/read round-trips correctly.
REQ-038 rd_en with the FIFO empty, alone and together with rx_done -> no rd_valid; in the combined case count=1 and the byte is read correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: stores {err, dout} frames, single-cycle registered reads,
// sticky overflow flag and a saturating count of erroneous frames.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done,
  input  logic [7:0]    dout,
  input  logic [2:0]    err,
  input  logic          rd_en,
  input  logic          clr_stat,
  output logic [7:0]    rd_data,
  output logic [2:0]    rd_err,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic [7:0]    err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [2:0]    rd_err_q, rd_err_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic rd_acc, wr_acc, drop, err_hit;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd_acc  = rd_en & ~empty;
  assign wr_acc  = rx_done & (~full | rd_acc);
  assign drop    = rx_done & full & ~rd_acc;
  assign err_hit = wr_acc & (err != 3'b000);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    err_cnt_d  = err_cnt_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      rd_data_d  = mem_q[rd_ptr_q][7:0];
      rd_err_d   = mem_q[rd_ptr_q][10:8];
      rd_valid_d = 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set beats clear for both statistics.
    if (clr_stat) begin
      ovf_d     = 1'b0;
      err_cnt_d = 8'd0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (err_hit) begin
      if (clr_stat) begin
        err_cnt_d = 8'd1;
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // Storage is not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= {err, dout};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= 8'd0;
      rd_err_q   <= 3'd0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, round trip, overflow, full read+write,
// error statistics, mid-operation reset and reads of an empty FIFO.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] dout;
  logic [2:0] err;
  logic       rd_en;
  logic       clr_stat;
  logic [7:0] rd_data;
  logic [2:0] rd_err;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       ovf;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo #(.DEPTH(8), .CW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_done  (rx_done),
    .dout     (dout),
    .err      (err),
    .rd_en    (rd_en),
    .clr_stat (clr_stat),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf      (ovf),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic [2:0] e);
    rx_done = 1'b1; dout = d; err = e;
    cycle();
    rx_done = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if ({rd_err, rd_data} !== 11'd0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0", {rd_err, rd_data}); end
    n_cmp++; if ({ovf, err_cnt} !== 9'd0) begin n_bad++; $display("FAIL reset_stats got %h want 0", {ovf, err_cnt}); end
  endtask

  task automatic test_round_trip();
    wr(8'hA5, 3'b000);
    cycle();
    n_cmp++; if (count !== 4'd1 || empty !== 1'b0) begin n_bad++; $display("FAIL rt_count got %0d/%b want 1/0", count, empty); end
    rd();
    n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL rt_valid got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 8'hA5 || rd_err !== 3'b000) begin n_bad++; $display("FAIL rt_data got %h/%b want a5/000", rd_data, rd_err); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rt_empty got %b want 1", empty); end
    cycle();
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin n_bad++; $display("FAIL rt_hold got %b/%h want 0/a5", rd_valid, rd_data); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) wr(8'(i), 3'b000);
    n_cmp++; if (full !== 1'b1 || count !== 4'd8) begin n_bad++; $display("FAIL ov_full got %b/%0d want 1/8", full, count); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ov_pre got %b want 0", ovf); end
    wr(8'hFF, 3'b000);
    n_cmp++; if (ovf !== 1'b1 || count !== 4'd8) begin n_bad++; $display("FAIL ov_set got %b/%0d want 1/8", ovf, count); end
    clr_stat = 1'b1;
    wr(8'hEE, 3'b000);
    clr_stat = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ov_set_wins got %b want 1", ovf); end
    for (int i = 1; i <= 8; i++) begin
      rd();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        n_bad++; $display("FAIL ov_read%0d got %b/%h want 1/%h", i, rd_valid, rd_data, 8'(i));
      end
    end
    rd();
    n_cmp++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin n_bad++; $display("FAIL ov_drained got %b/%b want 0/1", rd_valid, empty); end
    clr_stat = 1'b1;
    cycle();
    clr_stat = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ov_clear got %b want 0", ovf); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) wr(8'h11 + 8'(i), 3'b000);
    rx_done = 1'b1; dout = 8'h55; err = 3'b000; rd_en = 1'b1;
    cycle();
    rx_done = 1'b0; rd_en = 1'b0;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h11) begin n_bad++; $display("FAIL frw_oldest got %b/%h want 1/11", rd_valid, rd_data); end
    n_cmp++; if (count !== 4'd8 || ovf !== 1'b0) begin n_bad++; $display("FAIL frw_count got %0d/%b want 8/0", count, ovf); end
    for (int i = 1; i < 8; i++) begin
      rd();
      n_cmp++;
      if (rd_data !== 8'h11 + 8'(i)) begin n_bad++; $display("FAIL frw_read%0d got %h want %h", i, rd_data, 8'h11 + 8'(i)); end
    end
    rd();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h55 || empty !== 1'b1) begin
      n_bad++; $display("FAIL frw_last got %b/%h/%b want 1/55/1", rd_valid, rd_data, empty);
    end
  endtask

  task automatic test_err_cnt();
    wr(8'h01, 3'b001);
    wr(8'h02, 3'b100);
    wr(8'h03, 3'b000);
    n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL ec_three got %0d want 2", err_cnt); end
    rd();
    n_cmp++; if (rd_err !== 3'b001) begin n_bad++; $display("FAIL ec_rd_err0 got %b want 001", rd_err); end
    rd();
    n_cmp++; if (rd_err !== 3'b100) begin n_bad++; $display("FAIL ec_rd_err1 got %b want 100", rd_err); end
    rd();
    n_cmp++; if (rd_err !== 3'b000 || rd_data !== 8'h03) begin n_bad++; $display("FAIL ec_rd_err2 got %b/%h want 000/03", rd_err, rd_data); end
    clr_stat = 1'b1;
    cycle();
    clr_stat = 1'b0;
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL ec_clear got %0d want 0", err_cnt); end
    for (int i = 0; i < 300; i++) begin
      rx_done = 1'b1; dout = 8'(i); err = 3'b010; rd_en = 1'b1;
      cycle();
    end
    rx_done = 1'b0; rd_en = 1'b0;
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL ec_saturate got %0d want 255", err_cnt); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL ec_interleave_count got %0d want 1", count); end
    clr_stat = 1'b1;
    wr(8'h77, 3'b111);
    clr_stat = 1'b0;
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL ec_clr_with_err got %0d want 1", err_cnt); end
    rd();
    n_cmp++; if (rd_data !== 8'(299) || rd_err !== 3'b010) begin n_bad++; $display("FAIL ec_last_loop got %h/%b want 2b/010", rd_data, rd_err); end
    rd();
    n_cmp++; if (rd_data !== 8'h77 || empty !== 1'b1) begin n_bad++; $display("FAIL ec_drain got %h/%b want 77/1", rd_data, empty); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i), 3'b000);
    reset = 1'b0; rd_en = 1'b1;
    cycle();
    reset = 1'b1; rd_en = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL mr_valid got %b want 0", rd_valid); end
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL mr_state got %0d/%b/%b want 0/1/0", count, empty, ovf);
    end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL mr_rd_data got %h want 00", rd_data); end
    cycle();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL mr_late_valid got %b want 0", rd_valid); end
    wr(8'h3C, 3'b101);
    rd();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C || rd_err !== 3'b101) begin
      n_bad++; $display("FAIL mr_roundtrip got %b/%h/%b want 1/3c/101", rd_valid, rd_data, rd_err);
    end
  endtask

  task automatic test_empty_read();
    rd();
    n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd0 || rd_data !== 8'h3C) begin
      n_bad++; $display("FAIL er_alone got %b/%0d/%h want 0/0/3c", rd_valid, count, rd_data);
    end
    rx_done = 1'b1; dout = 8'h9A; err = 3'b000; rd_en = 1'b1;
    cycle();
    rx_done = 1'b0; rd_en = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd1) begin n_bad++; $display("FAIL er_combined got %b/%0d want 0/1", rd_valid, count); end
    rd();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h9A) begin n_bad++; $display("FAIL er_readback got %b/%h want 1/9a", rd_valid, rd_data); end
  endtask

  initial begin
    reset = 1'b0; rx_done = 1'b0; dout = 8'h00; err = 3'b000; rd_en = 1'b0; clr_stat = 1'b0;
    test_reset();
    test_round_trip();
    test_overflow();
    test_full_rw();
    test_err_cnt();
    test_mid_reset();
    test_empty_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
